// File: rtl/serv_ibus_prefetch.sv
// serv_ibus_prefetch
// -----------------------------------------------------------------------------
// Single-entry instruction prefetch buffer. It sits between the core's
// instruction fetch port and a Wishbone-classic instruction memory. Each
// demand fetch is served from memory, and then the next sequential word is
// prefetched into a one-word buffer. A request that hits the buffer completes
// its handshake one cycle after it is raised.
//
// Parameters
//   WITH_PREFETCH - 1 enables the prefetch buffer, 0 makes the block a
//                   registered pass-through (demand fetches only).
//
// Ports
//   clk        - clock
//   i_rst      - synchronous, active-high reset
//   i_flush    - invalidate the buffer and discard any in-flight prefetch
//   i_cpu_adr  - fetch address from the core ([1:0] ignored)
//   i_cpu_cyc  - fetch request, held until o_cpu_ack
//   o_cpu_rdt  - instruction word, valid with o_cpu_ack
//   o_cpu_ack  - single-cycle registered acknowledge
//   o_mem_adr  - memory word address ([1:0] always 00)
//   o_mem_cyc  - memory request, held until i_mem_ack
//   i_mem_rdt  - memory read data
//   i_mem_ack  - memory acknowledge (ignored while o_mem_cyc is low)
// -----------------------------------------------------------------------------
module serv_ibus_prefetch #(
  parameter bit WITH_PREFETCH = 1'b1
) (
  input  logic        clk,
  input  logic        i_rst,
  input  logic        i_flush,
  input  logic [31:0] i_cpu_adr,
  input  logic        i_cpu_cyc,
  output logic [31:0] o_cpu_rdt,
  output logic        o_cpu_ack,
  output logic [31:0] o_mem_adr,
  output logic        o_mem_cyc,
  input  logic [31:0] i_mem_rdt,
  input  logic        i_mem_ack
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DEMAND     = 2'd1,
    PREF       = 2'd2,
    PREF_STALE = 2'd3
  } state_t;

  state_t      state_q,     state_d;
  logic [31:0] cpu_rdt_q,   cpu_rdt_d;
  logic        cpu_ack_q,   cpu_ack_d;
  logic [31:0] mem_adr_q,   mem_adr_d;
  logic        mem_cyc_q,   mem_cyc_d;
  logic [31:0] buf_data_q,  buf_data_d;
  logic [29:0] buf_tag_q,   buf_tag_d;
  logic        buf_valid_q, buf_valid_d;
  logic        served_q,    served_d;

  logic        new_req;
  logic [29:0] req_word;
  logic [31:0] req_adr;
  logic        buf_hit;
  logic        pref_match;
  logic [31:0] next_adr;

  // The byte-offset bits of the fetch address carry no information here.
  logic unused_adr_bits;
  assign unused_adr_bits = ^i_cpu_adr[1:0];

  // Request decode. A request already acknowledged (served) must not be
  // treated as new again while the core still holds i_cpu_cyc, and the
  // cycle carrying the ack itself is excluded too.
  always_comb begin
    new_req    = i_cpu_cyc & ~served_q & ~cpu_ack_q;
    req_word   = i_cpu_adr[31:2];
    req_adr    = {i_cpu_adr[31:2], 2'b00};
    buf_hit    = buf_valid_q & (buf_tag_q == req_word);
    pref_match = (req_word == mem_adr_q[31:2]);
    next_adr   = mem_adr_q + 32'd4;
  end

  // Next-state logic for the fetch FSM and all its registered outputs.
  // o_mem_cyc always drops for at least one cycle after an ack: the states
  // that launch a new cycle from a finished one pass through a "gap" cycle
  // where mem_cyc_q is low, and raise it again from there.
  always_comb begin
    state_d     = state_q;
    cpu_rdt_d   = cpu_rdt_q;
    cpu_ack_d   = 1'b0;
    mem_adr_d   = mem_adr_q;
    mem_cyc_d   = mem_cyc_q;
    buf_data_d  = buf_data_q;
    buf_tag_d   = buf_tag_q;
    buf_valid_d = buf_valid_q;
    served_d    = i_cpu_cyc & (served_q | cpu_ack_q);

    if (i_flush) begin
      buf_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (new_req) begin
          // A flush in the same cycle overrides a hit.
          if (buf_hit && !i_flush) begin
            cpu_ack_d   = 1'b1;
            cpu_rdt_d   = buf_data_q;
            buf_valid_d = 1'b0;
            mem_adr_d   = req_adr + 32'd4;
            mem_cyc_d   = 1'b1;
            state_d     = PREF;
          end else begin
            mem_adr_d = req_adr;
            mem_cyc_d = 1'b1;
            state_d   = DEMAND;
          end
        end
      end

      DEMAND: begin
        if (!mem_cyc_q) begin
          mem_cyc_d = 1'b1;
        end else if (i_mem_ack) begin
          cpu_ack_d = 1'b1;
          cpu_rdt_d = i_mem_rdt;
          mem_cyc_d = 1'b0;
          if (WITH_PREFETCH) begin
            mem_adr_d = next_adr;
            state_d   = PREF;
          end else begin
            state_d = IDLE;
          end
        end
      end

      PREF: begin
        if (!mem_cyc_q) begin
          // Gap cycle before the prefetch launches. Nothing is in flight
          // yet, so a flush or a jump simply abandons the prefetch and lets
          // IDLE handle any request.
          if (i_flush || (new_req && !pref_match)) begin
            state_d = IDLE;
          end else begin
            mem_cyc_d = 1'b1;
          end
        end else if (i_mem_ack) begin
          mem_cyc_d = 1'b0;
          if (!i_flush && new_req && pref_match) begin
            // The core is already waiting for this very word.
            cpu_ack_d = 1'b1;
            cpu_rdt_d = i_mem_rdt;
            mem_adr_d = next_adr;
          end else if (i_flush || new_req) begin
            // Word is stale or unwanted; drop it and serve the request.
            if (new_req) begin
              mem_adr_d = req_adr;
              state_d   = DEMAND;
            end else begin
              state_d = IDLE;
            end
          end else begin
            buf_valid_d = 1'b1;
            buf_tag_d   = mem_adr_q[31:2];
            buf_data_d  = i_mem_rdt;
            state_d     = IDLE;
          end
        end else if (i_flush || (new_req && !pref_match)) begin
          state_d = PREF_STALE;
        end
      end

      PREF_STALE: begin
        // Wishbone classic has no abort, so the cycle is completed and the
        // returned word thrown away.
        if (mem_cyc_q && i_mem_ack) begin
          mem_cyc_d = 1'b0;
          if (new_req) begin
            mem_adr_d = req_adr;
            state_d   = DEMAND;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d   = IDLE;
        mem_cyc_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      cpu_rdt_q   <= 32'd0;
      cpu_ack_q   <= 1'b0;
      mem_adr_q   <= 32'd0;
      mem_cyc_q   <= 1'b0;
      buf_data_q  <= 32'd0;
      buf_tag_q   <= 30'd0;
      buf_valid_q <= 1'b0;
      served_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cpu_rdt_q   <= cpu_rdt_d;
      cpu_ack_q   <= cpu_ack_d;
      mem_adr_q   <= mem_adr_d;
      mem_cyc_q   <= mem_cyc_d;
      buf_data_q  <= buf_data_d;
      buf_tag_q   <= buf_tag_d;
      buf_valid_q <= buf_valid_d;
      served_q    <= served_d;
    end
  end

  assign o_cpu_rdt = cpu_rdt_q;
  assign o_cpu_ack = cpu_ack_q;
  assign o_mem_adr = mem_adr_q;
  assign o_mem_cyc = mem_cyc_q;

endmodule

// File: tb/tb_serv_ibus_prefetch.sv
// tb_serv_ibus_prefetch
// -----------------------------------------------------------------------------
// Directed bench for serv_ibus_prefetch. A small Wishbone memory model with
// programmable latency answers o_mem_cyc; its data word is a function of the
// address and a version number so that a refetch after flush is
// distinguishable from the stale buffered word.
// -----------------------------------------------------------------------------
module tb_serv_ibus_prefetch;

  logic        clk;
  logic        i_rst;
  logic        i_flush;
  logic [31:0] i_cpu_adr;
  logic        i_cpu_cyc;
  logic [31:0] o_cpu_rdt;
  logic        o_cpu_ack;
  logic [31:0] o_mem_adr;
  logic        o_mem_cyc;
  logic [31:0] i_mem_rdt;
  logic        i_mem_ack;

  int checks = 0;
  int errors = 0;

  // Memory model state
  bit          mem_en   = 1'b1;
  int          mem_lat  = 2;
  int          mem_wait = 0;
  logic [7:0]  mem_ver  = 8'd0;

  // Observation state
  logic [31:0] mem_log[$];
  logic        prev_mem_cyc = 1'b0;
  logic [31:0] prev_mem_adr = 32'd0;
  logic        prev_ack     = 1'b0;
  int          lat;
  logic [31:0] first_adr;

  serv_ibus_prefetch #(.WITH_PREFETCH(1'b1)) dut (
    .clk       (clk),
    .i_rst     (i_rst),
    .i_flush   (i_flush),
    .i_cpu_adr (i_cpu_adr),
    .i_cpu_cyc (i_cpu_cyc),
    .o_cpu_rdt (o_cpu_rdt),
    .o_cpu_ack (o_cpu_ack),
    .o_mem_adr (o_mem_adr),
    .o_mem_cyc (o_mem_cyc),
    .i_mem_rdt (i_mem_rdt),
    .i_mem_ack (i_mem_ack)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a, input logic [7:0] v);
    return {a[31:2], 2'b00} ^ 32'h5A00_C3C3 ^ {v, 24'h0};
  endfunction

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic cyc, input logic [31:0] adr);
    i_cpu_cyc = cyc;
    i_cpu_adr = adr;
  endtask

  // One clock: sample 1 time unit after the edge, run protocol monitors,
  // then advance the memory model.
  task automatic tick();
    @(posedge clk);
    #1;
    if (o_mem_cyc && !prev_mem_cyc) mem_log.push_back(o_mem_adr);
    check_output("ack_not_back_to_back", {31'd0, o_cpu_ack & prev_ack}, 32'd0);
    if (prev_mem_cyc && o_mem_cyc)
      check_output("mem_adr_stable_in_cyc", o_mem_adr, prev_mem_adr);
    prev_mem_cyc = o_mem_cyc;
    prev_mem_adr = o_mem_adr;
    prev_ack     = o_cpu_ack;
    if (mem_en) begin
      if (i_mem_ack) begin
        i_mem_ack = 1'b0;
        mem_wait  = 0;
      end else if (o_mem_cyc) begin
        mem_wait++;
        if (mem_wait >= mem_lat) begin
          i_mem_ack = 1'b1;
          i_mem_rdt = mem_word(o_mem_adr, mem_ver);
        end
      end else begin
        mem_wait = 0;
      end
    end
  endtask

  task automatic wait_ack(input string tag, input int bound, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!o_cpu_ack && n < bound);
    check_output(tag, {31'd0, o_cpu_ack}, 32'd1);
  endtask

  // Wait until the memory side has been quiet for three cycles.
  task automatic wait_idle(input string tag, input int bound);
    int quiet = 0;
    int n = 0;
    while (quiet < 3 && n < bound) begin
      tick();
      n++;
      quiet = o_mem_cyc ? 0 : quiet + 1;
    end
    check_output(tag, quiet, 3);
  endtask

  initial begin
    i_rst     = 1'b1;
    i_flush   = 1'b0;
    i_mem_ack = 1'b0;
    i_mem_rdt = 32'd0;
    apply_stimulus(1'b0, 32'd0);

    // Reset state
    tick();
    tick();
    check_output("rst_cpu_ack", {31'd0, o_cpu_ack}, 32'd0);
    check_output("rst_cpu_rdt", o_cpu_rdt, 32'd0);
    check_output("rst_mem_cyc", {31'd0, o_mem_cyc}, 32'd0);
    check_output("rst_mem_adr", o_mem_adr, 32'd0);
    check_output("rst_buf_valid", {31'd0, dut.buf_valid_q}, 32'd0);
    i_rst = 1'b0;
    tick();

    // Demand miss at 0x0, memory acks two cycles after cyc
    $display("[TB] demand fetch 0x0");
    apply_stimulus(1'b1, 32'h0000_0000);
    tick();
    check_output("miss_mem_cyc", {31'd0, o_mem_cyc}, 32'd1);
    check_output("miss_mem_adr", o_mem_adr, 32'h0000_0000);
    check_output("miss_no_early_ack", {31'd0, o_cpu_ack}, 32'd0);
    wait_ack("miss_ack", 20, lat);
    check_output("miss_ack_latency", lat, 2);
    check_output("miss_rdt", o_cpu_rdt, mem_word(32'h0, 8'd0));
    check_output("miss_mem_cyc_low", {31'd0, o_mem_cyc}, 32'd0);
    // Request held one extra cycle: must not be acked twice
    tick();
    check_output("served_no_reack", {31'd0, o_cpu_ack}, 32'd0);
    check_output("pref_cyc_start", {31'd0, o_mem_cyc}, 32'd1);
    check_output("pref_adr_4", o_mem_adr, 32'h0000_0004);
    apply_stimulus(1'b0, 32'h0000_0000);
    tick();
    tick();
    check_output("pref4_done_cyc", {31'd0, o_mem_cyc}, 32'd0);
    check_output("pref4_buf_valid", {31'd0, dut.buf_valid_q}, 32'd1);

    // Sequential hit at 0x4
    $display("[TB] sequential hit 0x4");
    mem_log.delete();
    apply_stimulus(1'b1, 32'h0000_0004);
    tick();
    check_output("hit_ack", {31'd0, o_cpu_ack}, 32'd1);
    check_output("hit_rdt", o_cpu_rdt, mem_word(32'h4, 8'd0));
    check_output("hit_pref_cyc", {31'd0, o_mem_cyc}, 32'd1);
    check_output("hit_pref_adr", o_mem_adr, 32'h0000_0008);
    first_adr = (mem_log.size() > 0) ? mem_log[0] : 32'hDEAD_BEEF;
    check_output("hit_no_fetch_of_4", first_adr, 32'h0000_0008);
    apply_stimulus(1'b0, 32'h0000_0004);
    wait_idle("idle_after_pref8", 40);
    check_output("pref8_buf_valid", {31'd0, dut.buf_valid_q}, 32'd1);

    // Flush, then request 0x8: must refetch the new memory contents
    $display("[TB] flush then fetch 0x8");
    mem_ver = 8'd1;
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    check_output("flush_buf_invalid", {31'd0, dut.buf_valid_q}, 32'd0);
    mem_log.delete();
    apply_stimulus(1'b1, 32'h0000_0008);
    wait_ack("flush_ack", 20, lat);
    check_output("flush_rdt_new", o_cpu_rdt, mem_word(32'h8, 8'd1));
    first_adr = (mem_log.size() > 0) ? mem_log[0] : 32'hDEAD_BEEF;
    check_output("flush_refetch_adr", first_adr, 32'h0000_0008);

    // Jump to 0x100 while prefetch of 0xC is in flight
    $display("[TB] jump during prefetch");
    mem_lat = 4;
    apply_stimulus(1'b0, 32'h0000_0008);
    tick();
    check_output("jump_pref_c_cyc", {31'd0, o_mem_cyc}, 32'd1);
    check_output("jump_pref_c_adr", o_mem_adr, 32'h0000_000C);
    mem_log.delete();
    apply_stimulus(1'b1, 32'h0000_0100);
    wait_ack("jump_ack", 40, lat);
    check_output("jump_rdt", o_cpu_rdt, mem_word(32'h100, 8'd1));
    check_output("jump_log_count", mem_log.size(), 1);
    first_adr = (mem_log.size() > 0) ? mem_log[0] : 32'hDEAD_BEEF;
    check_output("jump_demand_adr", first_adr, 32'h0000_0100);
    check_output("jump_stale_not_buffered", {31'd0, dut.buf_valid_q}, 32'd0);
    apply_stimulus(1'b0, 32'h0000_0100);
    mem_lat = 2;
    wait_idle("idle_after_jump", 40);

    // Wrap: demand at the top of the address space
    $display("[TB] address wrap");
    apply_stimulus(1'b1, 32'hFFFF_FFFC);
    wait_ack("wrap_ack", 20, lat);
    check_output("wrap_rdt", o_cpu_rdt, mem_word(32'hFFFF_FFFC, 8'd1));
    apply_stimulus(1'b0, 32'hFFFF_FFFC);
    tick();
    check_output("wrap_pref_cyc", {31'd0, o_mem_cyc}, 32'd1);
    check_output("wrap_pref_adr", o_mem_adr, 32'h0000_0000);

    // Reset in the middle of a memory cycle, then a stray memory ack
    $display("[TB] reset mid-transaction");
    i_rst = 1'b1;
    tick();
    check_output("midrst_mem_cyc", {31'd0, o_mem_cyc}, 32'd0);
    check_output("midrst_cpu_ack", {31'd0, o_cpu_ack}, 32'd0);
    i_rst     = 1'b0;
    mem_en    = 1'b0;
    i_mem_ack = 1'b1;
    i_mem_rdt = 32'h1234_5678;
    tick();
    check_output("stray_ack_no_cpu_ack_1", {31'd0, o_cpu_ack}, 32'd0);
    tick();
    check_output("stray_ack_no_cpu_ack_2", {31'd0, o_cpu_ack}, 32'd0);
    check_output("stray_ack_mem_cyc", {31'd0, o_mem_cyc}, 32'd0);
    i_mem_ack = 1'b0;
    mem_en    = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serv_ibus_prefetch.md
# serv_ibus_prefetch

Single-entry instruction prefetch buffer between the core's instruction bus master (bit-serial PC/control stage: `i_cpu_adr`, `i_cpu_cyc`, `o_cpu_ack`) and the external Wishbone-classic instruction memory. It serves each demand fetch and then prefetches the next sequential word, so straight-line code completes its fetch handshake one cycle after request. It forwards only: no decode, no PC arithmetic beyond the +4 prefetch address.

## Interface
- `WITH_PREFETCH`, 1 — 0 disables prefetch; the block becomes a registered pass-through.
- `clk` in 1 — clock.
- `i_rst` in 1 — reset: synchronous, active-high.
- `i_flush` in 1 — invalidate buffer and discard any in-flight prefetch (fence.i/trap).
- `i_cpu_adr` in 32 — fetch address; `[1:0]` ignored; stable while `i_cpu_cyc` high.
- `i_cpu_cyc` in 1 — fetch request; held until ack, then dropped for ≥1 cycle.
- `o_cpu_rdt` out 32 — instruction word, valid while `o_cpu_ack` high.
- `o_cpu_ack` out 1 — single-cycle registered ack.
- `o_mem_adr` out 32 — memory word address, `[1:0]`=00.
- `o_mem_cyc` out 1 — memory request; held until `i_mem_ack`.
- `i_mem_rdt` in 32 — memory data.
- `i_mem_ack` in 1 — memory ack; ignored while `o_mem_cyc` low.

## Operation
- Storage: `buf_data[31:0]`, `buf_tag[29:0]`, `buf_valid`; `served` flag.
- `served` is set when `o_cpu_ack` fires and cleared when `i_cpu_cyc` is low. New request = `i_cpu_cyc & !served & !o_cpu_ack`.
- FSM states: IDLE, DEMAND, PREF, PREF_STALE.
- IDLE, new request, hit (`buf_valid && buf_tag==i_cpu_adr[31:2]`):
  - Drive `o_cpu_ack` with `buf_data`.
  - Clear `buf_valid`.
  - Go to PREF at address `{i_cpu_adr[31:2],2'b00}+4`.
- IDLE, new request, miss: go to DEMAND at `{i_cpu_adr[31:2],2'b00}`.
- DEMAND, on `i_mem_ack`:
  - `o_cpu_rdt<=i_mem_rdt`, `o_cpu_ack<=1`.
  - Go to PREF at address+4 (IDLE if `WITH_PREFETCH=0`).
- PREF, on `i_mem_ack`:
  - If a pending request matches the prefetch address, forward the word as in DEMAND (buffer stays invalid), then go to PREF at +4.
  - Otherwise fill the buffer (`buf_valid<=1`) and go to IDLE.
- PREF, pending request with a different address:
  - Move to PREF_STALE.
  - PREF_STALE completes the memory cycle (no abort), discards the data, then goes to DEMAND for the request.
- `i_flush`:
  - Clears `buf_valid`.
  - In PREF, moves to PREF_STALE; the stale word is discarded, then the block goes to IDLE, or to DEMAND if a request is pending.
  - No effect in DEMAND (the demand word is still delivered).
- Address arithmetic is 32-bit modulo: prefetch after 0xFFFFFFFC uses 0x00000000.

## Timing
- Reset values:
  - `o_cpu_ack`=0, `o_cpu_rdt`=0, `o_mem_cyc`=0, `o_mem_adr`=0.
  - `buf_valid`=0, `served`=0, state IDLE.
- Reset mid-transaction: `o_mem_cyc` low the next cycle. A late `i_mem_ack` is ignored.
- Hit: request first visible in cycle N → `o_cpu_ack` in N+1; prefetch `o_mem_cyc` rises in N+1.
- Miss: request in N → `o_mem_cyc` in N+1; `i_mem_ack` in M → `o_mem_cyc` low in M+1 and `o_cpu_ack` in M+1.
- `o_mem_cyc` is low for ≥1 cycle between transactions: after a DEMAND ack, the prefetch starts in M+2.
- `o_mem_adr` changes only while `o_mem_cyc` is low.
- `o_cpu_ack` is never high in two consecutive cycles and never fires without a new request.
- Request and `i_flush` in the same IDLE cycle: the flush wins. The request is treated as a miss.

## Test plan
- Reset, request 0x00000000, memory acks 2 cycles after cyc → one `o_cpu_ack` carrying word@0. Next `o_mem_cyc` has `o_mem_adr`=0x4, starting 2 cycles after the memory ack.
- Sequential: after prefetch of 0x4 completes, request 0x4 → `o_cpu_ack` exactly 1 cycle later with word@4, with no memory cycle for 0x4. Prefetch of 0x8 starts in that same cycle.
- Jump during prefetch: request 0x100 while PREF 0x8 is in flight → 0x8 is completed and discarded, then DEMAND 0x100. Ack carries word@0x100; `buf_valid` is not set with word@0x8.
- Flush: buffer holds 0x8, pulse `i_flush`, request 0x8 → demand memory fetch issued and memory's new word@0x8 returned.
- Wrap: demand 0xFFFFFFFC → prefetch address 0x00000000.
- Reset asserted while `o_mem_cyc` is high → `o_mem_cyc` 0 the next cycle. A subsequent stray `i_mem_ack` produces no `o_cpu_ack`.
